matrix_skew_loader: RTL and testbench
=====================================

// Module: matrix_skew_loader
// PURPOSE
//  Consumes the byte stream popped from the input fifo (valid/yumi), gathers one
//  array_height_p x array_width_p matrix (row-major), then streams it into the
//  systolic array's row inputs with diagonal skew: row r is delayed r beats.
//  Sits directly downstream of the sipo -> edge_detector -> fifo chain.
// PARAMETERS
//  width_p         8  bits per matrix element
//  array_width_p   2  columns per matrix row (elements per row lane)
//  array_height_p  2  rows = output lanes to the systolic array
// PORTS
//  clk_i    in   1                        clock, posedge
//  reset_i  in   1                        reset, asynchronous, active-low
//  valid_i  in   1                        fifo has an element on data_i
//  data_i   in   width_p                  fifo head element
//  yumi_o   out  1                        pop fifo head this cycle
//  ready_i  in   1                        array accepts current beat
//  valid_o  out  1                        data_o holds a valid skewed beat
//  data_o   out  array_height_p*width_p   lane r at [r*width_p +: width_p]
//  busy_o   out  1                        high while in STREAM
// BEHAVIOUR
//  - N=W*H elements; B=W+H-1 beats per matrix. W,H >= 1; counters min 1 bit.
//  - reset_i low (async): state=LOAD, load_cnt=0, beat_cnt=0, buffer zeroed;
//    yumi_o=0, valid_o=0, busy_o=0, data_o=0. Release is synchronous to clk_i.
//  - States: LOAD, STREAM (2-state FSM).
//  - LOAD: yumi_o = valid_i (combinational; no path from ready_i). On each
//    pop, buf[load_cnt] <= data_i, load_cnt++. Pop with load_cnt==N-1 ->
//    STREAM next cycle, load_cnt <= 0. valid_o=0, data_o=0 in LOAD.
//  - STREAM: yumi_o=0 regardless of valid_i. valid_o=1, busy_o=1.
//    Beat t: lane r = A[r][t-r] if 0 <= t-r < W, else 0.
//    valid_o & ready_i -> beat_cnt++; at beat_cnt==B-1 -> LOAD, beat_cnt<=0.
//  - Latency: first beat valid the cycle after the N-th pop; B beats minimum.
//  - Backpressure: while valid_o & !ready_i, data_o and beat_cnt held stable.
//  - data_o/valid_o are pure functions of registered state (glitch-free
//    w.r.t. inputs); buffer written only in LOAD.
//  - Back-to-back matrices: ≥1 LOAD cycle per element; no overlap of load/stream.
//  - valid_i gaps in LOAD: no pop, counters hold, buffer unchanged.
//  - Reset mid-LOAD or mid-STREAM discards partial matrix; no stale beat after.
// STRUCTURE
//  - systolic_pkg: typedef enum logic [0:0] {LOAD, STREAM} skew_state_e;
//    function clog2_min1(n) for counter widths.
//  - One sub-module: mod_counter #(max_p) (en, wrap flag, async active-low
//    reset), instantiated for load_cnt (max N-1) and beat_cnt (max B-1).
//  - Buffer: flat N*width_p register; skew select is a combinational mux.
// TESTING  (W=H=2, width_p=8; A[0]={A1,A2}, A[1]={B1,B2})
//  1 Reset: hold reset_i=0 mid-run -> yumi_o=valid_o=busy_o=0, data_o=16'h0.
//  2 Load A1,A2,B1,B2, ready_i=1 -> 4 pops, then data_o 16'h00A1, 16'hB1A2,
//    16'hB200 on 3 consecutive cycles, then valid_o=0, yumi_o follows valid_i.
//  3 Backpressure: ready_i=0 for 3 cycles at beat 1 -> data_o holds 16'hB1A2,
//    valid_o stays 1; beat 2 (16'hB200) follows ready_i rising.
//  4 valid_i gaps (1,0,0,1,1,0,1) during LOAD -> exactly 4 pops, same 3 beats
//    as scenario 2; valid_i=1 in STREAM -> yumi_o=0 throughout.
//  5 Reset at beat 1 -> valid_o drops immediately; after release, load
//    C1,C2,D1,D2 -> beats 16'h00C1, 16'hD1C2, 16'hD200 (no A/B residue).
//  6 8 words queued in fifo -> first matrix streams, yumi_o=0 during its 3
//    beats, second matrix loads and streams correctly with no lost element.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic-array front end.
//   skew_state_e : LOAD (gathering a matrix) / STREAM (emitting skewed beats)
//   clog2_min1   : bits needed to count 0..n-1, never less than 1
package systolic_pkg;

    typedef enum logic [0:0] {
        LOAD   = 1'b0,
        STREAM = 1'b1
    } skew_state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo counter: counts 0..max_p, advancing on en and wrapping to 0.
//   clk_i   : clock, posedge
//   reset_i : asynchronous, active-low; clears count
//   en      : advance this cycle
//   count   : current value
//   wrap    : count is at max_p (next enabled cycle returns to 0)
module mod_counter
    import systolic_pkg::*;
#(
    parameter  int max_p    = 1,
    localparam int width_lp = clog2_min1(max_p + 1)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                en,
    output logic [width_lp-1:0] count,
    output logic                wrap
);

    assign wrap = (count == width_lp'(max_p));

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)  count <= '0;
        else if (en)   count <= wrap ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/matrix_skew_loader.sv
// Gathers one array_height_p x array_width_p matrix (row-major) from a fifo
// pop interface, then streams it to the systolic array rows with diagonal
// skew: row r is delayed r beats, giving W+H-1 beats per matrix.
//   clk_i, reset_i : clock (posedge), asynchronous active-low reset
//   valid_i/data_i : fifo head element;  yumi_o pops it (LOAD only)
//   ready_i        : array accepts the current beat
//   valid_o/data_o : skewed beat, lane r at [r*width_p +: width_p]
//   busy_o         : high while streaming
module matrix_skew_loader
    import systolic_pkg::*;
#(
    parameter int width_p        = 8,
    parameter int array_width_p  = 2,
    parameter int array_height_p = 2
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              valid_i,
    input  logic [width_p-1:0]                data_i,
    output logic                              yumi_o,
    input  logic                              ready_i,
    output logic                              valid_o,
    output logic [array_height_p*width_p-1:0] data_o,
    output logic                              busy_o
);

    localparam int N   = array_width_p * array_height_p;
    localparam int B   = array_width_p + array_height_p - 1;
    localparam int LCW = clog2_min1(N);
    localparam int BCW = clog2_min1(B);

    skew_state_e state_q, state_d;

    logic [LCW-1:0] load_cnt;
    logic [BCW-1:0] beat_cnt;
    logic           load_last, beat_last;
    logic           load_en, beat_en;

    logic [N-1:0][width_p-1:0]              buf_q;
    logic [array_height_p-1:0][width_p-1:0] lane_d;

    // Pop and beat-advance qualifiers come from registered state, so neither
    // counter can move in the wrong phase.
    assign load_en = (state_q == LOAD)   && valid_i;
    assign beat_en = (state_q == STREAM) && ready_i;

    mod_counter #(.max_p(N - 1)) u_load_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en      (load_en),
        .count   (load_cnt),
        .wrap    (load_last)
    );

    mod_counter #(.max_p(B - 1)) u_beat_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en      (beat_en),
        .count   (beat_cnt),
        .wrap    (beat_last)
    );

    // Element buffer, one register per matrix element, indexed row-major.
    for (genvar e = 0; e < N; e++) begin : g_buf
        always_ff @(posedge clk_i or negedge reset_i) begin
            if (!reset_i)                                  buf_q[e] <= '0;
            else if (load_en && load_cnt == LCW'(e))       buf_q[e] <= data_i;
        end
    end

    // FSM: state register
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state_q <= LOAD;
        else          state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (load_en && load_last) state_d = STREAM;
            STREAM:  if (beat_en && beat_last) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // FSM: outputs. yumi_o is the only output with an input path (valid_i).
    always_comb begin
        yumi_o  = 1'b0;
        valid_o = 1'b0;
        busy_o  = 1'b0;
        case (state_q)
            LOAD:    yumi_o = valid_i;
            STREAM:  begin valid_o = 1'b1; busy_o = 1'b1; end
            default: ;
        endcase
    end

    // Skew select: on beat t, lane r shows column t-r of row r when that
    // column exists, otherwise zero. Forced to zero outside STREAM.
    always_comb begin
        lane_d = '0;
        if (state_q == STREAM) begin
            for (int r = 0; r < array_height_p; r++) begin
                for (int c = 0; c < array_width_p; c++) begin
                    if (int'(beat_cnt) == r + c)
                        lane_d[r] = buf_q[r*array_width_p + c];
                end
            end
        end
    end

    assign data_o = lane_d;

endmodule

// File: tb/tb_matrix_skew_loader.sv
// Self-checking bench for matrix_skew_loader (W=H=2, width 8). A queue models
// the upstream fifo; expected beats are derived from the matrix contents with
// the diagonal rule lane r = A[r][t-r].
module tb_matrix_skew_loader;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [7:0]  data_i = '0;
    logic        yumi_o;
    logic        ready_i = 1'b0;
    logic        valid_o;
    logic [15:0] data_o;
    logic        busy_o;

    int tests = 0;
    int fails = 0;

    logic [7:0] fq[$];

    always #5 clk_i = ~clk_i;

    matrix_skew_loader #(.width_p(8), .array_width_p(2), .array_height_p(2)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .yumi_o  (yumi_o),
        .ready_i (ready_i),
        .valid_o (valid_o),
        .data_o  (data_o),
        .busy_o  (busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: beat t of a 2x2 matrix m (row-major).
    function automatic logic [15:0] skew_beat(input logic [7:0] m[4], input int t);
        logic [15:0] v;
        v = '0;
        for (int r = 0; r < 2; r++) begin
            int c;
            c = t - r;
            if (c >= 0 && c < 2) v[r*8 +: 8] = m[r*2 + c];
        end
        return v;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, valid_o, 0);
        chk({tag, "_busy"},  busy_o,  0);
        chk({tag, "_data"},  data_o,  0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b0;
        valid_i = 1'b0;
        #1;
        check_idle("reset");
        chk("reset_yumi", yumi_o, 0);
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b1;
    endtask

    // Loads one matrix from fq then streams it. vlen/slen > 0 select a
    // directed valid/ready pattern (LSB first), otherwise random.
    // abort_beat >= 0 applies reset when that beat is on the output.
    task automatic run_matrix(input string tag, input logic [31:0] vpat, input int vlen,
                              input logic [31:0] spat, input int slen, input int abort_beat);
        logic [7:0] m[4];
        int pops, cyc, t;
        if (fq.size() < 4) begin
            chk({tag, "_fifo_underfilled"}, fq.size(), 4);
            return;
        end
        for (int i = 0; i < 4; i++) m[i] = fq[i];
        pops = 0; cyc = 0; t = 0;
        while (pops < 4 && cyc < 200) begin
            valid_i = (fq.size() > 0) && ((vlen > 0) ? vpat[cyc % vlen] : ($urandom_range(3) != 0));
            data_i  = (fq.size() > 0) ? fq[0] : 8'h00;
            ready_i = 1'($urandom_range(1));
            @(negedge clk_i);
            chk({tag, "_load_yumi"},  yumi_o,  valid_i);
            chk({tag, "_load_valid"}, valid_o, 0);
            chk({tag, "_load_data"},  data_o,  0);
            @(posedge clk_i);
            if (valid_i) begin void'(fq.pop_front()); pops++; end
            #1 cyc++;
        end
        if (pops < 4) chk({tag, "_load_timeout"}, pops, 4);
        cyc = 0;
        while (t < 3 && cyc < 100) begin
            valid_i = (fq.size() > 0);
            data_i  = (fq.size() > 0) ? fq[0] : 8'h00;
            ready_i = (slen > 0) ? spat[cyc % slen] : ($urandom_range(2) != 0);
            @(negedge clk_i);
            chk({tag, "_stream_valid"}, valid_o, 1);
            chk({tag, "_stream_busy"},  busy_o,  1);
            chk({tag, "_stream_yumi"},  yumi_o,  0);
            chk({tag, "_stream_data"},  data_o,  skew_beat(m, t));
            if (t == abort_beat) begin
                reset_i = 1'b0;
                #1;
                check_idle({tag, "_abort"});
                chk({tag, "_abort_yumi"}, yumi_o, 0);
                @(posedge clk_i);
                #1 reset_i = 1'b1;
                ready_i = 1'b0;
                valid_i = 1'b0;
                return;
            end
            @(posedge clk_i);
            if (ready_i) t++;
            #1 cyc++;
        end
        if (t < 3) chk({tag, "_stream_timeout"}, t, 3);
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk_i);
        check_idle({tag, "_after"});
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // 1: power-on reset, then reset mid-LOAD discards the partial matrix
        do_reset();
        fq = '{8'h11, 8'h22};
        for (int i = 0; i < 2; i++) begin
            valid_i = 1'b1; data_i = fq[0];
            @(posedge clk_i); void'(fq.pop_front()); #1;
        end
        valid_i = 1'b0;
        do_reset();

        // 2: directed A1,A2,B1,B2 with ready always high
        fq = '{8'hA1, 8'hA2, 8'hB1, 8'hB2};
        run_matrix("basic", 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1, -1);

        // 3: three stalled cycles while beat 1 is presented
        fq = '{8'hA1, 8'hA2, 8'hB1, 8'hB2};
        run_matrix("stall", 32'hFFFF_FFFF, 1, 32'b110001, 6, -1);

        // 4: valid_i gaps during LOAD, more data waiting during STREAM
        fq = '{8'hA1, 8'hA2, 8'hB1, 8'hB2, 8'h5A};
        run_matrix("gaps", 32'b1011001, 7, 32'hFFFF_FFFF, 1, -1);
        fq.delete();

        // 5: reset while beat 1 is on the output, then a fresh matrix
        fq = '{8'hA1, 8'hA2, 8'hB1, 8'hB2};
        run_matrix("abort", 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1, 1);
        fq = '{8'hC1, 8'hC2, 8'hD1, 8'hD2};
        run_matrix("fresh", 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1, -1);

        // 6: eight words queued back-to-back
        fq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_matrix("b2b0", 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1, -1);
        run_matrix("b2b1", 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1, -1);

        // Randomized matrices with random gaps and stalls
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 4 + int'($urandom_range(3)); i++) fq.push_back(8'($urandom));
            run_matrix("rand", 32'h0, 0, 32'h0, 0, -1);
            if (fq.size() < 4) fq.delete();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
